// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared SPI state encoding and default widths
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_t;

  // The slave's instruction register width must agree with SPI_DATA_W_DEF
  localparam int SPI_DATA_W_DEF  = 4;
  localparam int SPI_CLK_DIV_DEF = 2;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake and SPI pin bundle for spi_master
interface spi_master_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W_DEF
);

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              CS;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start,
    input  tx_data,
    input  MISO,
    output busy,
    output done,
    output rx_data,
    output sclk,
    output CS,
    output MOSI
  );

  modport slave (
    output start,
    output tx_data,
    output MISO,
    input  busy,
    input  done,
    input  rx_data,
    input  sclk,
    input  CS,
    input  MOSI
  );

endinterface

// File: rtl/spi_master_clk_div.sv
// rtl/spi_master_clk_div.sv - half-period down-counter, tick when expired
module spi_clk_div #(
  parameter int CLK_DIV = spi_pkg::SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(CLK_DIV - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI initiator, MSB first, registered outputs
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W_DEF,
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  spi_master_if.master bus
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  spi_state_t r_state;
  spi_state_t w_next_state;

  logic              w_tick;
  logic              w_load;
  logic              w_accept;
  logic              w_cs_nxt;
  logic              w_sclk_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_tx_shift;
  logic [DATA_W-1:0] w_rx_shift;

  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_cs;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rx_data;

  // Every state change reloads the divider, so each phase lasts CLK_DIV cycles
  assign w_load     = (w_next_state != r_state);
  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_tx_shift = r_tx_sh << 1;
  assign w_rx_shift = (r_rx_sh << 1) | DATA_W'(bus.MISO);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cs_nxt     = 1'b1;
    w_sclk_nxt   = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      IDLE:    if (bus.start) w_next_state = SETUP;
      SETUP:   if (w_tick)    w_next_state = HIGH;
      HIGH:    if (w_tick)    w_next_state = (r_bit_cnt == '0) ? HOLD : LOW;
      LOW:     if (w_tick)    w_next_state = HIGH;
      HOLD:    if (w_tick)    w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase

    // Pin levels follow the state being entered, keeping every output registered
    w_cs_nxt   = (w_next_state == IDLE);
    w_sclk_nxt = (w_next_state == HIGH);
    w_busy_nxt = (w_next_state != IDLE);
    w_done_nxt = (r_state == HOLD) && (w_next_state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_cs   <= w_cs_nxt;
      r_sclk <= w_sclk_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;

      if (w_accept) begin
        r_tx_sh   <= bus.tx_data;
        r_mosi    <= bus.tx_data[DATA_W-1];
        r_bit_cnt <= BW'(DATA_W - 1);
      end

      if ((r_state == HIGH) && w_tick) begin
        r_rx_sh <= w_rx_shift;
      end

      if ((r_state == HIGH) && (w_next_state == LOW)) begin
        r_tx_sh   <= w_tx_shift;
        r_mosi    <= w_tx_shift[DATA_W-1];
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end

      if (w_done_nxt) begin
        r_rx_data <= r_rx_sh;
      end
    end
  end

  assign bus.CS      = r_cs;
  assign bus.sclk    = r_sclk;
  assign bus.MOSI    = r_mosi;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed scoreboard bench for spi_master
module tb_spi_master;
  import spi_pkg::*;

  localparam int DW    = SPI_DATA_W_DEF;
  localparam int CD    = SPI_CLK_DIV_DEF;
  localparam int FRAME = CD * (2 * DW + 1);

  typedef struct packed {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } exp_t;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic clk_en   = 1'b1;
  logic miso_one = 1'b0;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int busy_cnt  = 0;
  int rise_cnt  = 0;
  int done_cnt  = 0;
  int mosi_viol = 0;
  int done_times[$];
  exp_t exp_q[$];

  logic [DW-1:0] mosi_word = '0;
  logic [DW-1:0] slave_ir  = '0;
  logic          prev_mosi = 1'b0;

  spi_master_if #(.DATA_W(DW)) bus ();

  spi_master #(
    .DATA_W  (DW),
    .CLK_DIV (CD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.MISO = miso_one ? 1'b1 : bus.MOSI;

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 slave model: samples MOSI on rising sclk while selected
  always @(posedge bus.sclk) begin
    rise_cnt++;
    mosi_word = {mosi_word[DW-2:0], bus.MOSI};
    if (!bus.CS) slave_ir = {slave_ir[DW-2:0], bus.MOSI};
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      busy_cnt  = 0;
      rise_cnt  = 0;
      mosi_word = '0;
      prev_mosi = bus.MOSI;
    end else begin
      if ((bus.MOSI !== prev_mosi) && bus.sclk) mosi_viol++;
      prev_mosi = bus.MOSI;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_times.push_back(cyc);
        check("busy_len", busy_cnt, FRAME);
        check("sclk_rises", rise_cnt, DW);
        check("cs_at_done", bus.CS, 1);
        check("busy_at_done", bus.busy, 0);
        busy_cnt = 0;
        rise_cnt = 0;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rx_data", bus.rx_data, e.rx);
          check("mosi_bits", mosi_word, e.tx);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] tx, input logic [DW-1:0] exp_rx);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = tx;
    exp_q.push_back({tx, exp_rx});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while ((done_cnt < target) && (n < 4 * FRAME)) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, done_cnt >= target, 1);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_cs"}, bus.CS, 1);
    check({tag, "_sclk"}, bus.sclk, 0);
    check({tag, "_mosi"}, bus.MOSI, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_rx"}, bus.rx_data, 0);
  endtask

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.tx_data = '0;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_pins("reset");
    rst = 1'b0;

    // Loopback, 4'hA
    send(4'hA, 4'hA);
    wait_done(1, "loop_a");
    @(negedge clk);
    check("done_width", bus.done, 0);
    check("rx_hold", bus.rx_data, 4'hA);

    // MISO tied high; slave model receives 4'h3
    miso_one = 1'b1;
    send(4'h3, 4'hF);
    wait_done(2, "miso_one");
    check("slave_ir", slave_ir, 4'h3);
    miso_one = 1'b0;

    // Start and new tx_data while busy are ignored
    send(4'h6, 4'h6);
    repeat (4) @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = 4'h5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(3, "ignore");
    repeat (2 * FRAME) @(negedge clk);
    check("ignored_start", done_cnt, 3);

    // Start held high: two frames back to back
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = 4'hC;
    exp_q.push_back({4'hC, 4'hC});
    exp_q.push_back({4'hC, 4'hC});
    wait_done(4, "b2b_first");
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("cs_gap", bus.CS, 0);
    wait_done(5, "b2b_second");
    check("done_spacing", done_times[4] - done_times[3], FRAME + 1);

    // Async reset after 2nd rising sclk with the clock stopped
    send(4'hD, 4'hD);
    n = 0;
    while ((rise_cnt < 2) && (n < 4 * FRAME)) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pre_reset_rises", rise_cnt, 2);
    check("pre_reset_sclk", bus.sclk, 1);
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_idle_pins("async_rst");
    exp_q.delete();
    #2 clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("no_done_after_rst", done_cnt, 5);

    send(4'h9, 4'h9);
    wait_done(6, "after_rst");

    check("mosi_stable", mosi_viol, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
